wb_merge_buffer: RTL
====================

// Module: wb_merge_buffer
// PURPOSE
// Sits between the execute stage and the scoreboard write-back ports.
// Fixed-latency and async FUs (FLU, load, store, FPU, CV-X-IF) produce results that cannot be stalled.
// Per-source FIFOs absorb bursts; a round-robin arbiter drains them onto NR_WB_PORTS scoreboard write ports.
// One commit-side status (empty_o) tells issue/commit logic when all results are delivered.
// PARAMETERS
// NR_SRC         5   number of result sources (0=FLU,1=load,2=store,3=FPU,4=X)
// NR_WB_PORTS    2   scoreboard write-back ports driven per cycle (1..NR_SRC)
// DEPTH          2   entries per source FIFO (power of 2, >=2)
// XLEN           64  result width
// TRANS_ID_BITS  3   scoreboard transaction-id width
// PORTS
// clk_i           in   1                    clock; one clock; reset is synchronous and active-high
// rst_i           in   1                    synchronous active-high reset
// flush_i         in   1                    pipeline flush, drop all buffered results
// src_valid_i     in   NR_SRC               per-source result valid (no ready; cannot stall)
// src_trans_id_i  in   NR_SRC*TRANS_ID_BITS per-source scoreboard id
// src_result_i    in   NR_SRC*XLEN          per-source result, or exception cause if ex_valid
// src_ex_valid_i  in   NR_SRC               per-source exception flag
// wb_valid_o      out  NR_WB_PORTS          write-back port valid
// wb_trans_id_o   out  NR_WB_PORTS*TRANS_ID_BITS  write-back id
// wb_result_o     out  NR_WB_PORTS*XLEN     write-back data/cause
// wb_ex_valid_o   out  NR_WB_PORTS          write-back exception flag
// empty_o         out  1                    all FIFOs empty
// overflow_o      out  1                    sticky: a result was dropped on a full FIFO
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): all FIFOs empty, rr_q=0, overflow_o=0. While FIFOs empty: wb_valid_o=0, empty_o=1.
//   Reset mid-operation discards everything buffered.
// - Enqueue: src_valid_i[s]=1 at edge N writes {id,result,ex} into FIFO s.
//   No combinational path src_* -> wb_*.
// - wb_* are combinational from FIFO heads and rr_q; uncontended latency is exactly 1 cycle.
// - Arbitration: scan sources from rr_q upward modulo NR_SRC.
//   The k-th non-empty source found drives port k (k < NR_WB_PORTS). At most one entry per source per cycle.
//   Unused ports: valid=0, id/result/ex=0.
// - Granted heads are dequeued at the edge.
//   If any grant occurred, rr_q <= (last granted index + 1) mod NR_SRC; otherwise rr_q is held.
// - Ordering: strictly FIFO within a source; no ordering guarantee across sources.
// - Full FIFO with src_valid_i=1:
//   - same-cycle dequeue of that FIFO -> the entry is accepted;
//   - otherwise the new entry is dropped, contents are unchanged, and overflow_o <= 1.
//   overflow_o is cleared only by rst_i.
// - flush_i=1:
//   - wb_valid_o forced 0 that cycle; no dequeue;
//   - all FIFOs cleared at the edge; src_valid_i in the flush cycle is discarded; rr_q <= 0;
//   - overflow_o is unaffected.
// - empty_o=1 iff every FIFO count==0; it is registered-state derived and updates the cycle after the final dequeue edge.
// - Counters: per-FIFO rd/wr pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
// TESTING (NR_SRC=5, NR_WB_PORTS=2, DEPTH=2)
// 1. src0 valid cyc0, id=3, result=0xDEAD
//    -> cyc1: wb_valid_o=2'b01, id0=3, res0=0xDEAD; cyc2: empty_o=1.
// 2. src0..4 valid cyc0 with ids 0..4, idle after
//    -> cyc1 ports={0,1}; cyc2 {2,3}; cyc3 port0=4, port1 invalid; rr_q wraps to 0.
// 3. All 5 sources valid cyc0..2
//    -> src4 full at cyc2 without grant, entry dropped; overflow_o=1 from cyc3 and stays 1 after flush.
// 4. Scenario-2 fill, flush_i at cyc1 with src1 valid
//    -> wb_valid_o=0 cyc1 and cyc2; empty_o=1 cyc2; src1 entry lost.
// 5. FIFO full (ids 1,2), granted and new id=5 arrives same cycle
//    -> accepted, no overflow; id 2 then id 5 are delivered in order.
// 6. rst_i asserted with 3 entries buffered
//    -> next cycle wb_valid_o=0, empty_o=1, overflow_o=0.

Source files
------------

// File: rtl/wb_merge_buffer.sv
// Write-back merge buffer: per-source result FIFOs drained round-robin onto
// NR_WB_PORTS scoreboard write-back ports, with flush, empty and sticky overflow status.
module wb_merge_buffer #(
  parameter int unsigned NR_SRC        = 5,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic [NR_SRC-1:0]                      src_valid_i,
  input  logic [NR_SRC*TRANS_ID_BITS-1:0]        src_trans_id_i,
  input  logic [NR_SRC*XLEN-1:0]                 src_result_i,
  input  logic [NR_SRC-1:0]                      src_ex_valid_i,
  output logic [NR_WB_PORTS-1:0]                 wb_valid_o,
  output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [NR_WB_PORTS*XLEN-1:0]            wb_result_o,
  output logic [NR_WB_PORTS-1:0]                 wb_ex_valid_o,
  output logic                                   empty_o,
  output logic                                   overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int unsigned ENT_W = TRANS_ID_BITS + XLEN + 1;

  // Handshake: neither side has a ready. A source result with src_valid_i=1 is
  // captured at the edge (or dropped if its FIFO is full and not draining), and a
  // port with wb_valid_o=1 is consumed by the scoreboard at that same edge.

  logic [ENT_W-1:0]     mem_q    [NR_SRC][DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q [NR_SRC];
  logic [PTR_W-1:0]     wr_ptr_q [NR_SRC];
  logic [CNT_W-1:0]     cnt_q    [NR_SRC];
  logic [SRC_W-1:0]     rr_q;
  logic [SRC_W-1:0]     rr_d;
  logic                 overflow_q;

  logic [NR_SRC-1:0]      not_empty;
  logic [NR_SRC-1:0]      grant;
  logic [NR_SRC-1:0]      enq;
  logic [SRC_W-1:0]       port_sel [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0] port_vld;

  always_comb begin
    not_empty = '0;
    enq       = '0;
    for (int s = 0; s < int'(NR_SRC); s++) begin
      not_empty[s] = (cnt_q[s] != '0);
      // A full FIFO still accepts when its head leaves in the same cycle.
      enq[s] = src_valid_i[s] && ((cnt_q[s] != CNT_W'(DEPTH)) || grant[s]);
    end
  end

  always_comb begin
    int k;
    int idx;
    grant    = '0;
    port_vld = '0;
    rr_d     = rr_q;
    k        = 0;
    idx      = 0;
    for (int p = 0; p < int'(NR_WB_PORTS); p++) port_sel[p] = '0;
    for (int i = 0; i < int'(NR_SRC); i++) begin
      idx = (int'(rr_q) + i) % int'(NR_SRC);
      if (!flush_i && not_empty[idx] && (k < int'(NR_WB_PORTS))) begin
        grant[idx]  = 1'b1;
        port_sel[k] = SRC_W'(idx);
        port_vld[k] = 1'b1;
        rr_d        = SRC_W'((idx + 1) % int'(NR_SRC));
        k           = k + 1;
      end
    end
  end

  always_comb begin
    logic [ENT_W-1:0] head;
    wb_valid_o    = '0;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_ex_valid_o = '0;
    head          = '0;
    for (int p = 0; p < int'(NR_WB_PORTS); p++) begin
      head = port_vld[p] ? mem_q[port_sel[p]][rd_ptr_q[port_sel[p]]] : '0;
      wb_valid_o[p]                                = port_vld[p];
      wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] = head[ENT_W-1 -: TRANS_ID_BITS];
      wb_result_o[p*XLEN +: XLEN]                  = head[XLEN:1];
      wb_ex_valid_o[p]                             = head[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < int'(NR_SRC); s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      for (int s = 0; s < int'(NR_SRC); s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_q <= '0;
    end else begin
      for (int s = 0; s < int'(NR_SRC); s++) begin
        if (enq[s])   wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
        if (grant[s]) rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
        cnt_q[s] <= cnt_q[s] + CNT_W'(enq[s]) - CNT_W'(grant[s]);
        if (src_valid_i[s] && !enq[s]) overflow_q <= 1'b1;
      end
      rr_q <= rr_d;
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int s = 0; s < int'(NR_SRC); s++) begin
        if (enq[s]) begin
          mem_q[s][wr_ptr_q[s]] <= {src_trans_id_i[s*TRANS_ID_BITS +: TRANS_ID_BITS],
                                    src_result_i[s*XLEN +: XLEN],
                                    src_ex_valid_i[s]};
        end
      end
    end
  end

  assign empty_o    = ~|not_empty;
  assign overflow_o = overflow_q;

endmodule
